// File: rtl/stat_veto_pkg.sv
// rtl/stat_veto_pkg.sv - shared types and constants for the multi-channel veto statistics block
// Contents: FSM state type, readout select codes, default widths, width helper.
package stat_veto_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LIVE = 1'b1
  } state_t;

  localparam logic RD_SEL_EDGE = 1'b0;
  localparam logic RD_SEL_DUR  = 1'b1;

  localparam int DEF_N_CH      = 8;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_DUR_W     = 32;
  localparam int DEF_GATE_LIVE = 1;
  localparam int DEF_SPILL_W   = 16;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stat_veto_chan.sv
// rtl/stat_veto_chan.sv - one veto channel: edge detect, saturating counters, shadow snapshot
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr           start of spill: counters and sat flags restart from zero this cycle
//   snap          end of spill: shadows take the live counters
//   en            count enable
//   veto          veto level of this channel
//   sh_edge/sh_dur        shadow edge / duration counts
//   sh_sat_e/sh_sat_d     shadow saturation flags
module stat_veto_chan
  import stat_veto_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DUR_W = DEF_DUR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             snap,
  input  logic             en,
  input  logic             veto,
  output logic [CNT_W-1:0] sh_edge,
  output logic [DUR_W-1:0] sh_dur,
  output logic             sh_sat_e,
  output logic             sh_sat_d
);

  logic             pre_veto;
  logic [CNT_W-1:0] edge_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             sat_e;
  logic             sat_d;

  logic             inc_e;
  logic             inc_d;
  logic [CNT_W-1:0] edge_base;
  logic [DUR_W-1:0] dur_base;
  logic             sat_e_base;
  logic             sat_d_base;
  logic             full_e;
  logic             full_d;

  assign inc_e = en & veto & ~pre_veto;
  assign inc_d = en & veto;

  // The clear is folded in ahead of the increment so an event in the
  // spill's first cycle is still counted.
  assign edge_base  = clr ? '0 : edge_cnt;
  assign dur_base   = clr ? '0 : dur_cnt;
  assign sat_e_base = clr ? 1'b0 : sat_e;
  assign sat_d_base = clr ? 1'b0 : sat_d;

  assign full_e = &edge_base;
  assign full_d = &dur_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_veto <= 1'b0;
      edge_cnt <= '0;
      dur_cnt  <= '0;
      sat_e    <= 1'b0;
      sat_d    <= 1'b0;
      sh_edge  <= '0;
      sh_dur   <= '0;
      sh_sat_e <= 1'b0;
      sh_sat_d <= 1'b0;
    end else begin
      pre_veto <= veto;
      // A count at all-ones holds; the lost increment is what raises sat.
      edge_cnt <= (inc_e && !full_e) ? edge_base + CNT_W'(1) : edge_base;
      dur_cnt  <= (inc_d && !full_d) ? dur_base + DUR_W'(1) : dur_base;
      sat_e    <= sat_e_base | (inc_e & full_e);
      sat_d    <= sat_d_base | (inc_d & full_d);
      // Shadows take the registered counts, i.e. everything up to the last
      // live cycle; events in the falling cycle itself are not included.
      if (snap) begin
        sh_edge  <= edge_cnt;
        sh_dur   <= dur_cnt;
        sh_sat_e <= sat_e;
        sh_sat_d <= sat_d;
      end
    end
  end

endmodule

// File: rtl/stat_veto_multi.sv
// rtl/stat_veto_multi.sv - per-spill veto edge/duration statistics over N_CH channels
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_live       live/spill window level
//   in_veto       veto levels, bit i = channel i
//   rd_ch/rd_sel  readout channel and counter select (edge / duration)
//   rd_data       registered shadow value, zero-extended; 0 for rd_ch >= N_CH
//   rd_sat        registered shadow saturation flag
//   snap_valid    one-cycle pulse when the shadow set has been updated
//   spill_cnt     completed spills since reset, wrapping
//   busy          high while a spill is in progress
module stat_veto_multi
  import stat_veto_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DUR_W     = DEF_DUR_W,
  parameter int GATE_LIVE = DEF_GATE_LIVE,
  parameter int SPILL_W   = DEF_SPILL_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_live,
  input  logic [N_CH-1:0]                  in_veto,
  input  logic [$clog2(N_CH):0]            rd_ch,
  input  logic                             rd_sel,
  output logic [max_w(CNT_W, DUR_W)-1:0]   rd_data,
  output logic                             rd_sat,
  output logic                             snap_valid,
  output logic [SPILL_W-1:0]               spill_cnt,
  output logic                             busy
);

  localparam int RD_W = max_w(CNT_W, DUR_W);
  localparam int CH_W = $clog2(N_CH) + 1;

  state_t state;
  state_t state_nxt;

  logic pre_live;
  logic live_rise;
  logic live_fall;
  logic en;
  logic clr;
  logic snap;

  logic [CNT_W-1:0] sh_edge [N_CH];
  logic [DUR_W-1:0] sh_dur  [N_CH];
  logic [N_CH-1:0]  sh_sat_e;
  logic [N_CH-1:0]  sh_sat_d;

  logic [RD_W-1:0]  rd_data_nxt;
  logic             rd_sat_nxt;

  assign live_rise = in_live & ~pre_live;
  assign live_fall = ~in_live & pre_live;
  assign en        = in_live | (GATE_LIVE == 0);
  assign busy      = (state == ST_LIVE);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    snap      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (live_rise) begin
          state_nxt = ST_LIVE;
          clr       = 1'b1;
        end
      end
      ST_LIVE: begin
        if (live_fall) begin
          state_nxt = ST_IDLE;
          snap      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pre_live   <= 1'b0;
      spill_cnt  <= '0;
      snap_valid <= 1'b0;
      rd_data    <= '0;
      rd_sat     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pre_live   <= in_live;
      snap_valid <= snap;
      if (snap) begin
        spill_cnt <= spill_cnt + SPILL_W'(1);
      end
      rd_data    <= rd_data_nxt;
      rd_sat     <= rd_sat_nxt;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    stat_veto_chan #(
      .CNT_W(CNT_W),
      .DUR_W(DUR_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .snap    (snap),
      .en      (en),
      .veto    (in_veto[g]),
      .sh_edge (sh_edge[g]),
      .sh_dur  (sh_dur[g]),
      .sh_sat_e(sh_sat_e[g]),
      .sh_sat_d(sh_sat_d[g])
    );
  end

  // Out-of-range channels match no entry and fall through to zero.
  always_comb begin
    rd_data_nxt = '0;
    rd_sat_nxt  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        if (rd_sel == RD_SEL_DUR) begin
          rd_data_nxt = RD_W'(sh_dur[i]);
          rd_sat_nxt  = sh_sat_d[i];
        end else begin
          rd_data_nxt = RD_W'(sh_edge[i]);
          rd_sat_nxt  = sh_sat_e[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_stat_veto_multi.sv
// tb/tb_stat_veto_multi.sv - self-checking bench for stat_veto_multi (three builds side by side)
// Builds: k=0 defaults, k=1 CNT_W=4, k=2 GATE_LIVE=0; all share one stimulus.
module tb_stat_veto_multi;

  localparam int N_CH = 8;
  localparam int NK   = 3;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic in_live;
  logic [N_CH-1:0] in_veto;
  logic [3:0] rd_ch;
  logic rd_sel;

  logic [NK-1:0][31:0] rd_data;
  logic [NK-1:0][15:0] spill_cnt;
  logic [NK-1:0]       rd_sat;
  logic [NK-1:0]       snap_valid;
  logic [NK-1:0]       busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  stat_veto_multi #(.N_CH(N_CH), .CNT_W(32), .DUR_W(32), .GATE_LIVE(1), .SPILL_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_live(in_live), .in_veto(in_veto), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data[0]), .rd_sat(rd_sat[0]), .snap_valid(snap_valid[0]),
    .spill_cnt(spill_cnt[0]), .busy(busy[0]));

  stat_veto_multi #(.N_CH(N_CH), .CNT_W(4), .DUR_W(32), .GATE_LIVE(1), .SPILL_W(16)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_live(in_live), .in_veto(in_veto), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data[1]), .rd_sat(rd_sat[1]), .snap_valid(snap_valid[1]),
    .spill_cnt(spill_cnt[1]), .busy(busy[1]));

  stat_veto_multi #(.N_CH(N_CH), .CNT_W(32), .DUR_W(32), .GATE_LIVE(0), .SPILL_W(16)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .in_live(in_live), .in_veto(in_veto), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data[2]), .rd_sat(rd_sat[2]), .snap_valid(snap_valid[2]),
    .spill_cnt(spill_cnt[2]), .busy(busy[2]));

  // Reference model: per-spill tallies kept as plain integers.
  longint m_ce  [NK][N_CH];
  longint m_cd  [NK][N_CH];
  bit     m_se  [NK][N_CH];
  bit     m_sd  [NK][N_CH];
  longint m_she [NK][N_CH];
  longint m_shd [NK][N_CH];
  bit     m_shse[NK][N_CH];
  bit     m_shsd[NK][N_CH];
  longint m_rd  [NK];
  bit     m_rs  [NK];
  bit     m_sv, m_busy, m_pl;
  bit [N_CH-1:0] m_pv;
  int     m_spill;

  function automatic longint edge_max(int k);
    return (k == 1) ? 64'd15 : MAX32;
  endfunction

  function automatic bit gated(int k);
    return (k != 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        m_ce[k][i] = 0; m_cd[k][i] = 0; m_se[k][i] = 0; m_sd[k][i] = 0;
        m_she[k][i] = 0; m_shd[k][i] = 0; m_shse[k][i] = 0; m_shsd[k][i] = 0;
      end
      m_rd[k] = 0; m_rs[k] = 0;
    end
    m_sv = 0; m_busy = 0; m_pl = 0; m_pv = '0; m_spill = 0;
  endtask

  task automatic model_edge();
    bit rise, fall, en;
    int ch;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = in_live && !m_pl;
    fall = !in_live && m_pl;
    ch = int'(rd_ch);
    for (int k = 0; k < NK; k++) begin
      // readout shows the shadow set as it stood before this edge
      if (ch < N_CH) begin
        m_rd[k] = rd_sel ? m_shd[k][ch] : m_she[k][ch];
        m_rs[k] = rd_sel ? m_shsd[k][ch] : m_shse[k][ch];
      end else begin
        m_rd[k] = 0; m_rs[k] = 0;
      end
      en = in_live || !gated(k);
      for (int i = 0; i < N_CH; i++) begin
        if (fall) begin
          m_she[k][i] = m_ce[k][i]; m_shd[k][i] = m_cd[k][i];
          m_shse[k][i] = m_se[k][i]; m_shsd[k][i] = m_sd[k][i];
        end
        if (rise) begin
          m_ce[k][i] = 0; m_cd[k][i] = 0; m_se[k][i] = 0; m_sd[k][i] = 0;
        end
        if (en && in_veto[i] && !m_pv[i]) begin
          if (m_ce[k][i] == edge_max(k)) m_se[k][i] = 1;
          else m_ce[k][i] = m_ce[k][i] + 1;
        end
        if (en && in_veto[i]) begin
          if (m_cd[k][i] == MAX32) m_sd[k][i] = 1;
          else m_cd[k][i] = m_cd[k][i] + 1;
        end
      end
    end
    m_sv = fall;
    if (fall) m_spill = (m_spill + 1) % 65536;
    m_busy = in_live;
    m_pl = in_live;
    m_pv = in_veto;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NK; k++) begin
      check($sformatf("model rd_data[%0d]", k), 64'(rd_data[k]), m_rd[k]);
      check($sformatf("model rd_sat[%0d]", k), 64'(rd_sat[k]), 64'(m_rs[k]));
      check($sformatf("model snap_valid[%0d]", k), 64'(snap_valid[k]), 64'(m_sv));
      check($sformatf("model spill_cnt[%0d]", k), 64'(spill_cnt[k]), 64'(m_spill));
      check($sformatf("model busy[%0d]", k), 64'(busy[k]), 64'(m_busy));
    end
  endtask

  task automatic cyc(bit live, logic [N_CH-1:0] veto);
    in_live = live;
    in_veto = veto;
    step();
  endtask

  task automatic rd(int ch, bit sel);
    rd_ch  = 4'(ch);
    rd_sel = sel;
    step();
  endtask

  typedef struct {
    int     ch;
    bit     sel;
    longint exp;
    bit     sat;
  } rd_vec_t;

  rd_vec_t tbl [11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 5, 0};
    tbl[1]  = '{0, 1, 15, 0};
    tbl[2]  = '{1, 0, 1, 0};
    tbl[3]  = '{1, 1, 100, 0};
    tbl[4]  = '{2, 0, 1, 0};
    tbl[5]  = '{2, 1, 1, 0};
    tbl[6]  = '{3, 0, 7, 0};
    tbl[7]  = '{3, 1, 7, 0};
    tbl[8]  = '{4, 0, 0, 0};
    tbl[9]  = '{8, 0, 0, 0};
    tbl[10] = '{15, 1, 0, 0};

    model_reset();
    rst_n = 1'b0; in_live = 1'b0; in_veto = '0; rd_ch = '0; rd_sel = 1'b0;
    repeat (3) step();
    for (int k = 0; k < NK; k++) begin
      check("reset rd_data", 64'(rd_data[k]), 0);
      check("reset spill_cnt", 64'(spill_cnt[k]), 0);
      check("reset busy", 64'(busy[k]), 0);
      check("reset snap_valid", 64'(snap_valid[k]), 0);
    end
    rst_n = 1'b1;
    repeat (2) cyc(0, '0);

    // Spill 1: ch0 five 3-cycle pulses, ch1 high throughout, ch2 edge on the
    // rising cycle of live, ch3 seven single-cycle pulses.
    for (int t = 0; t < 100; t++) begin
      logic [N_CH-1:0] v;
      v = '0;
      v[0] = (t >= 10 && t < 60 && (t % 10) < 3);
      v[1] = 1'b1;
      v[2] = (t == 0);
      v[3] = (t >= 70 && t < 84 && (t % 2) == 0);
      cyc(1, v);
    end
    cyc(0, '0);
    for (int k = 0; k < NK; k++) begin
      check("spill1 snap_valid pulse", 64'(snap_valid[k]), 1);
      check("spill1 spill_cnt", 64'(spill_cnt[k]), 1);
    end
    cyc(0, '0);
    for (int k = 0; k < NK; k++) check("spill1 snap_valid drop", 64'(snap_valid[k]), 0);

    foreach (tbl[j]) begin
      rd(tbl[j].ch, tbl[j].sel);
      for (int k = 0; k < NK; k++) begin
        check($sformatf("tbl%0d rd_data[%0d]", j, k), 64'(rd_data[k]), tbl[j].exp);
        check($sformatf("tbl%0d rd_sat[%0d]", j, k), 64'(rd_sat[k]), 64'(tbl[j].sat));
      end
    end

    // Spill 2 without vetoes: reads during the spill still show the old ch3.
    rd_ch = 4'd3; rd_sel = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cyc(1, '0);
      check("live read ch3 edge", 64'(rd_data[0]), 7);
    end
    cyc(0, '0);
    check("fall-edge read ch3 edge", 64'(rd_data[0]), 7);
    cyc(0, '0);
    check("post-snap read ch3 edge", 64'(rd_data[0]), 0);
    check("spill2 spill_cnt", 64'(spill_cnt[0]), 2);

    // Spill 3: 20 edges on ch0 saturates the 4-bit build only.
    for (int t = 0; t < 41; t++) cyc(1, N_CH'(t < 40 && (t % 2) == 0));
    cyc(0, '0);
    rd(0, 0);
    check("sat edge c32", 64'(rd_data[0]), 20);
    check("sat flag c32", 64'(rd_sat[0]), 0);
    check("sat edge c4", 64'(rd_data[1]), 15);
    check("sat flag c4", 64'(rd_sat[1]), 1);
    rd(0, 1);
    check("sat dur c4", 64'(rd_data[1]), 20);
    // Spill 4: two edges, sat flag cleared by the new spill.
    for (int t = 0; t < 6; t++) cyc(1, N_CH'(t == 1 || t == 3));
    cyc(0, '0);
    rd(0, 0);
    check("resat edge c4", 64'(rd_data[1]), 2);
    check("resat flag c4", 64'(rd_sat[1]), 0);

    // Edges outside the window: whatever the ungated build tallies there is
    // wiped by the next spill's clear, so every build snapshots zero.
    for (int t = 0; t < 6; t++) cyc(0, (t % 2 == 0) ? N_CH'(8'h20) : '0);
    for (int t = 0; t < 5; t++) cyc(1, '0);
    cyc(0, '0);
    rd(5, 0);
    for (int k = 0; k < NK; k++) check($sformatf("outside edges[%0d]", k), 64'(rd_data[k]), 0);

    // Reset in mid-spill with live held high.
    for (int t = 0; t < 5; t++) cyc(1, (t % 2 == 0) ? '1 : '0);
    rst_n = 1'b0;
    cyc(1, '0);
    check("midreset busy low", 64'(busy[0]), 0);
    rst_n = 1'b1;
    cyc(1, '0);
    for (int k = 0; k < NK; k++) begin
      check("midreset busy", 64'(busy[k]), 1);
      check("midreset spill_cnt", 64'(spill_cnt[k]), 0);
    end
    rd(1, 1);
    check("midreset shadow ch1 dur", 64'(rd_data[0]), 0);
    rd(N_CH, 0);
    check("rd_ch=N_CH data", 64'(rd_data[0]), 0);
    check("rd_ch=N_CH sat", 64'(rd_sat[0]), 0);
    cyc(0, '0);
    cyc(0, '0);

    // Random traffic against the model: long spills first, then short
    // spills including single-cycle live pulses, with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, (n < 2000) ? 39 : 2) == 0) in_live = ~in_live;
      in_veto = N_CH'($urandom) & N_CH'($urandom);
      rd_ch   = 4'($urandom_range(0, 15));
      rd_sel  = 1'($urandom);
      rst_n   = ($urandom_range(0, 599) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
